// File: rtl/game_pkg.sv
// Shared game encodings and the collision monitor state set.
// Imported by the collision monitor and its overlap helper.
package game_pkg;

  localparam int COORD_W = 10;

  localparam logic [1:0] GS_INIT    = 2'b00;
  localparam logic [1:0] GS_IN_GAME = 2'b01;
  localparam logic [1:0] GS_DEAD    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    GRACE,
    ARMED,
    CONFIRM,
    HIT,
    DONE
  } mon_state_e;

endpackage

// File: rtl/box_overlap.sv
// Half-open axis-aligned box overlap test, purely combinational.
// Degenerate boxes (x0>=x1 or y0>=y1) never report a hit.
module box_overlap
  import game_pkg::*;
#(
  parameter int COORD_W = game_pkg::COORD_W
) (
  input  logic               valid,
  input  logic [COORD_W-1:0] ax0,
  input  logic [COORD_W-1:0] ax1,
  input  logic [COORD_W-1:0] ay0,
  input  logic [COORD_W-1:0] ay1,
  input  logic [COORD_W-1:0] bx0,
  input  logic [COORD_W-1:0] bx1,
  input  logic [COORD_W-1:0] by0,
  input  logic [COORD_W-1:0] by1,
  output logic               hit
);

  logic a_ok;
  logic b_ok;
  logic x_ov;
  logic y_ov;

  assign a_ok = (ax0 < ax1) & (ay0 < ay1);
  assign b_ok = (bx0 < bx1) & (by0 < by1);
  assign x_ov = (ax0 < bx1) & (bx0 < ax1);
  assign y_ov = (ay0 < by1) & (by0 < ay1);
  assign hit  = valid & a_ok & b_ok & x_ov & y_ov;

endmodule

// File: rtl/collision_monitor.sv
// Confirms dino/obstacle overlaps per frame and raises a collision
// request to the game FSM, held until the FSM acknowledges with DEAD.
module collision_monitor
  import game_pkg::*;
#(
  parameter int COORD_W        = game_pkg::COORD_W,
  parameter int CONFIRM_FRAMES = 2,
  parameter int GRACE_FRAMES   = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           game_state,
  input  logic                 frame_tick,
  input  logic [COORD_W-1:0]   dino_x0,
  input  logic [COORD_W-1:0]   dino_x1,
  input  logic [COORD_W-1:0]   dino_y0,
  input  logic [COORD_W-1:0]   dino_y1,
  input  logic [1:0]           obs_valid,
  input  logic [2*COORD_W-1:0] obs_x0,
  input  logic [2*COORD_W-1:0] obs_x1,
  input  logic [2*COORD_W-1:0] obs_y0,
  input  logic [2*COORD_W-1:0] obs_y1,
  output logic                 collided,
  output logic                 hit_slot,
  output logic                 grace_active
);

  localparam int GW = (GRACE_FRAMES > 0) ?
                      $clog2(GRACE_FRAMES + 1) : 1;
  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [GW-1:0] GRACE_LD = GW'(GRACE_FRAMES);
  localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM_FRAMES);

  mon_state_e state_q, state_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [CW-1:0] conf_q, conf_d;
  logic          slot_q, slot_d;
  logic          p1_v_q, p1_v_d;
  logic [1:0]    p1_ov_q, p1_ov_d;
  logic [1:0]    ov;
  logic          in_game;
  logic          dead;
  logic          init;
  logic          any_ov;
  logic          low_slot;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    box_overlap #(.COORD_W(COORD_W)) u_box (
      .valid (obs_valid[g]),
      .ax0   (dino_x0),
      .ax1   (dino_x1),
      .ay0   (dino_y0),
      .ay1   (dino_y1),
      .bx0   (obs_x0[g*COORD_W +: COORD_W]),
      .bx1   (obs_x1[g*COORD_W +: COORD_W]),
      .by0   (obs_y0[g*COORD_W +: COORD_W]),
      .by1   (obs_y1[g*COORD_W +: COORD_W]),
      .hit   (ov[g])
    );
  end

  assign in_game  = (game_state == GS_IN_GAME);
  assign dead     = (game_state == GS_DEAD);
  assign init     = (game_state == GS_INIT) | (&game_state);
  assign any_ov   = |p1_ov_q;
  assign low_slot = ~p1_ov_q[0];

  // A tick seen while leaving IN_GAME is dropped here.
  always_comb begin
    p1_v_d  = frame_tick & in_game;
    p1_ov_d = ov & {2{p1_v_d}};
  end

  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    conf_d  = conf_q;
    slot_d  = slot_q;
    if ((state_q inside {GRACE, ARMED, CONFIRM}) && !in_game) begin
      state_d = dead ? DONE : IDLE;
      grace_d = '0;
      conf_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_game) begin
            if (GRACE_FRAMES > 0) begin
              state_d = GRACE;
              grace_d = GRACE_LD;
            end else begin
              state_d = ARMED;
            end
          end
        end
        GRACE: begin
          if (p1_v_q) begin
            if (grace_q <= GW'(1)) begin
              state_d = ARMED;
              grace_d = '0;
            end else begin
              grace_d = grace_q - GW'(1);
            end
          end
        end
        ARMED: begin
          if (p1_v_q && any_ov) begin
            if (CONFIRM_FRAMES == 1) begin
              state_d = HIT;
              conf_d  = CONF_MAX;
              slot_d  = low_slot;
            end else begin
              state_d = CONFIRM;
              conf_d  = CW'(1);
            end
          end
        end
        CONFIRM: begin
          if (p1_v_q) begin
            if (!any_ov) begin
              state_d = ARMED;
              conf_d  = '0;
            end else if (conf_q + CW'(1) >= CONF_MAX) begin
              state_d = HIT;
              conf_d  = CONF_MAX;
              slot_d  = low_slot;
            end else begin
              conf_d = conf_q + CW'(1);
            end
          end
        end
        HIT: begin
          if (dead || init) begin
            state_d = dead ? DONE : IDLE;
            conf_d  = '0;
            grace_d = '0;
          end
        end
        DONE: begin
          if (init) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grace_q <= '0;
      conf_q  <= '0;
      slot_q  <= 1'b0;
      p1_v_q  <= 1'b0;
      p1_ov_q <= '0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      conf_q  <= conf_d;
      slot_q  <= slot_d;
      p1_v_q  <= p1_v_d;
      p1_ov_q <= p1_ov_d;
    end
  end

  assign collided     = (state_q == HIT);
  assign grace_active = (state_q == GRACE);
  assign hit_slot     = slot_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Randomized bench for collision_monitor against a frame-level
// model: grace frames, overlap streaks, request/ack lifecycle.
module tb_collision_monitor;

  localparam int CW    = 10;
  localparam int CONF  = 2;
  localparam int GRACE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    game_state = 2'b00;
  logic          frame_tick = 1'b0;
  logic [CW-1:0] dx0 = '0, dx1 = '0, dy0 = '0, dy1 = '0;
  logic [1:0]    obs_valid = 2'b00;
  logic [CW-1:0] ox0[2], ox1[2], oy0[2], oy1[2];
  logic [2*CW-1:0] obs_x0, obs_x1, obs_y0, obs_y1;
  logic          collided, hit_slot, grace_active;

  int n_chk = 0;
  int n_fail = 0;

  // Model: 0 out of game, 1 playing, 2 waiting for INIT
  int m_st = 0;
  int m_frames = 0;
  int m_streak = 0;
  bit m_hit = 0;
  bit m_slot = 0;

  assign obs_x0 = {ox0[1], ox0[0]};
  assign obs_x1 = {ox1[1], ox1[0]};
  assign obs_y0 = {oy0[1], oy0[0]};
  assign obs_y1 = {oy1[1], oy1[0]};

  always #5 clk = ~clk;

  collision_monitor #(
    .COORD_W        (CW),
    .CONFIRM_FRAMES (CONF),
    .GRACE_FRAMES   (GRACE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_state   (game_state),
    .frame_tick   (frame_tick),
    .dino_x0      (dx0),
    .dino_x1      (dx1),
    .dino_y0      (dy0),
    .dino_y1      (dy1),
    .obs_valid    (obs_valid),
    .obs_x0       (obs_x0),
    .obs_x1       (obs_x1),
    .obs_y0       (obs_y0),
    .obs_y1       (obs_y1),
    .collided     (collided),
    .hit_slot     (hit_slot),
    .grace_active (grace_active)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit ov(int i);
    int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
    ax0 = dx0; ax1 = dx1; ay0 = dy0; ay1 = dy1;
    bx0 = ox0[i]; bx1 = ox1[i]; by0 = oy0[i]; by1 = oy1[i];
    if (!obs_valid[i]) return 0;
    if (ax1 <= ax0 || ay1 <= ay0) return 0;
    if (bx1 <= bx0 || by1 <= by0) return 0;
    return (ax0 < bx1) && (bx0 < ax1) &&
           (ay0 < by1) && (by0 < ay1);
  endfunction

  function automatic void model_gs(logic [1:0] g);
    if (g == 2'b01) begin
      if (m_st == 0) begin
        m_st = 1; m_frames = 0; m_streak = 0; m_hit = 0;
      end
    end else if (g == 2'b10) begin
      if (m_st == 1) begin
        m_st = 2; m_hit = 0; m_streak = 0;
      end
    end else begin
      m_st = 0; m_hit = 0; m_streak = 0;
    end
  endfunction

  function automatic void model_frame();
    bit a, b;
    a = ov(0);
    b = ov(1);
    if (m_st != 1 || m_hit) return;
    if (m_frames < GRACE) m_frames++;
    else if (a || b) begin
      m_streak++;
      if (m_streak >= CONF) begin
        m_hit = 1;
        m_slot = a ? 1'b0 : 1'b1;
      end
    end else m_streak = 0;
  endfunction

  task automatic chk_outs(string tag);
    bit ga;
    ga = (m_st == 1) && !m_hit && (m_frames < GRACE);
    check({tag, ".col"}, 32'(collided), 32'(m_hit));
    check({tag, ".slot"}, 32'(hit_slot), 32'(m_slot));
    check({tag, ".grace"}, 32'(grace_active), 32'(ga));
  endtask

  task automatic set_gs(logic [1:0] g, string tag);
    @(negedge clk);
    game_state = g;
    @(posedge clk);
    #1;
    model_gs(g);
    chk_outs(tag);
  endtask

  task automatic frame(string tag);
    @(negedge clk);
    frame_tick = 1'b1;
    model_frame();
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    chk_outs(tag);
  endtask

  task automatic frames(int n, string tag);
    for (int i = 0; i < n; i++) frame(tag);
  endtask

  task automatic pulse_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_st = 0; m_hit = 0; m_slot = 0;
    m_frames = 0; m_streak = 0;
    chk_outs({tag, ".async"});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_gs(game_state);
    chk_outs({tag, ".rel"});
  endtask

  task automatic set_dino(int x0, int x1, int y0, int y1);
    dx0 = CW'(x0); dx1 = CW'(x1);
    dy0 = CW'(y0); dy1 = CW'(y1);
  endtask

  task automatic set_obs(int s, int x0, int x1, int y0, int y1);
    ox0[s] = CW'(x0); ox1[s] = CW'(x1);
    oy0[s] = CW'(y0); oy1[s] = CW'(y1);
  endtask

  task automatic rand_boxes();
    int x, y;
    x = $urandom_range(5, 20);
    y = $urandom_range(5, 20);
    set_dino(x, x + $urandom_range(0, 14),
             y, y + $urandom_range(0, 14));
    for (int s = 0; s < 2; s++) begin
      x = $urandom_range(0, 30);
      y = $urandom_range(0, 30);
      set_obs(s, x, x + $urandom_range(0, 14),
              y, y + $urandom_range(0, 14));
    end
    obs_valid = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int r;
    set_obs(0, 0, 0, 0, 0);
    set_obs(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Overlap from frame 0: grace, confirm, hit on slot 0
    set_dino(10, 20, 10, 20);
    set_obs(0, 15, 25, 10, 20);
    obs_valid = 2'b01;
    set_gs(2'b01, "t1.enter");
    frames(5, "t1.frame");
    set_gs(2'b10, "t1.dead");
    set_gs(2'b00, "t1.init");

    // Broken streak, hold, acknowledge, ignore until INIT
    set_gs(2'b01, "t2.enter");
    obs_valid = 2'b00;
    frames(3, "t2.grace");
    obs_valid = 2'b01; frame("t2.ov1");
    obs_valid = 2'b00; frame("t2.clr");
    obs_valid = 2'b01; frame("t2.ov2");
    frame("t2.ov3");
    repeat (20) @(posedge clk);
    #1;
    chk_outs("t2.hold");
    set_gs(2'b10, "t2.dead");
    frames(3, "t2.ign");
    set_gs(2'b01, "t2.still");
    frame("t2.ign2");
    set_gs(2'b00, "t2.init");

    // Edge contact is not a hit; one pixel overlap is
    set_gs(2'b01, "t3.enter");
    set_obs(0, 20, 30, 10, 20);
    frames(5, "t3.touch");
    set_obs(0, 19, 30, 10, 20);
    frames(2, "t3.hit");

    // INIT without DEAD drops the request, grace restarts
    set_gs(2'b00, "t5.init");
    set_gs(2'b01, "t5.enter");
    frames(5, "t5.regrace");
    set_gs(2'b11, "t5.gs11");

    // Slot priority: invalid slot 0 ignored, lowest wins
    set_gs(2'b01, "t4.enter");
    set_obs(0, 12, 18, 12, 18);
    set_obs(1, 5, 15, 5, 15);
    obs_valid = 2'b10;
    frames(5, "t4.s1");
    set_gs(2'b00, "t4.init");
    set_gs(2'b01, "t4.enter2");
    obs_valid = 2'b11;
    frames(5, "t4.s0");
    set_gs(2'b00, "t4.init2");

    // Tick on the exit cycle is discarded
    set_gs(2'b01, "sim.enter");
    frames(4, "sim.pre");
    @(negedge clk);
    frame_tick = 1'b1;
    game_state = 2'b00;
    model_gs(2'b00);
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("sim.exit");

    // Reset mid-CONFIRM and mid-HIT
    set_gs(2'b01, "t6.enter");
    frames(4, "t6.conf");
    pulse_reset("t6.rc");
    frames(5, "t6.again");
    pulse_reset("t6.rh");
    frames(4, "t6.after");

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 72) begin
        rand_boxes();
        frame("rnd.frame");
      end else if (r < 82) set_gs(2'b01, "rnd.game");
      else if (r < 88) set_gs(2'b10, "rnd.dead");
      else if (r < 94) set_gs(2'b00, "rnd.init");
      else if (r < 98) set_gs(2'b11, "rnd.gs11");
      else pulse_reset("rnd.rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
